// File: rtl/fpaddsub_norm_shift_pipe_pkg.sv
// Shared types and constants for the FP add/sub post-adder normalizer.
// The stage payload is sized from the default widths below.
package fpaddsub_pkg;

   localparam int DEF_MAN_W = 23;
   localparam int DEF_EXP_W = 8;
   localparam int LZ_W      = $clog2(DEF_MAN_W + 3);

   localparam logic [DEF_EXP_W-1:0] EXP_ONES = '1;

   typedef struct packed {
      logic zero;
      logic uflow;
      logic oflow;
   } flags_t;

   typedef struct packed {
      logic                   sign;
      logic [DEF_EXP_W:0]     exp;
      logic [DEF_MAN_W+1:0]   man;
      logic [LZ_W-1:0]        lz;
      logic                   sticky;
      flags_t                 flags;
   } stage_t;

endpackage

// File: rtl/fpaddsub_norm_shift_pipe_if.sv
// Input/output stream bundle of the normalizer; master is the upstream/downstream
// environment, slave is the pipeline itself.
interface fpaddsub_norm_shift_pipe_if #(
   parameter int MAN_W = fpaddsub_pkg::DEF_MAN_W,
   parameter int EXP_W = fpaddsub_pkg::DEF_EXP_W
) ();

   logic             in_valid;
   logic             in_ready;
   logic [MAN_W+1:0] in_sum;
   logic [EXP_W-1:0] in_exp;
   logic             in_sign;

   logic             out_valid;
   logic             out_ready;
   logic [MAN_W:0]   out_man;
   logic [EXP_W-1:0] out_exp;
   logic             out_sign;
   logic             out_sticky;
   logic             out_zero;
   logic             out_uflow;
   logic             out_oflow;

   modport master (
      output in_valid, in_sum, in_exp, in_sign, out_ready,
      input  in_ready, out_valid, out_man, out_exp, out_sign,
             out_sticky, out_zero, out_uflow, out_oflow
   );

   modport slave (
      input  in_valid, in_sum, in_exp, in_sign, out_ready,
      output in_ready, out_valid, out_man, out_exp, out_sign,
             out_sticky, out_zero, out_uflow, out_oflow
   );

endinterface

// File: rtl/fpaddsub_norm_shift_pipe_lzc.sv
// Leading-zero counter, combinational; returns W for an all-zero input.
module fpaddsub_lzc #(
   parameter int W  = fpaddsub_pkg::DEF_MAN_W + 2,
   parameter int CW = fpaddsub_pkg::LZ_W
) (
   input  logic [W-1:0]  d,
   output logic [CW-1:0] cnt
);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      cnt = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (d[i]) cnt = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/fpaddsub_norm_shift_pipe.sv
// Post-adder normalizer: 3-stage pipeline, 3-cycle latency, 1 beat/cycle.
// Each stage advances when empty or when the next stage advances; out_* hold while stalled.
module fpaddsub_norm_shift_pipe #(
   parameter int MAN_W = fpaddsub_pkg::DEF_MAN_W,
   parameter int EXP_W = fpaddsub_pkg::DEF_EXP_W
) (
   input logic                       clk,
   input logic                       rst,
   fpaddsub_norm_shift_pipe_if.slave bus
);
   import fpaddsub_pkg::*;

   localparam int SUM_W = MAN_W + 2;

   logic             s1_vld, s2_vld, s3_vld;
   logic             s1_adv, s2_adv, s3_adv;
   logic             s1_sign;
   logic [EXP_W-1:0] s1_exp;
   logic [SUM_W-1:0] s1_sum;
   logic [LZ_W-1:0]  s1_lz;
   logic [LZ_W-1:0]  in_lz;
   stage_t           s2_nxt, s2;
   logic             carry, zero;
   logic [LZ_W-1:0]  shl;
   logic [EXP_W:0]   exp_inc;
   logic [MAN_W:0]   o_man;
   logic [EXP_W-1:0] o_exp;
   logic             o_sign, o_sticky;
   flags_t           o_flags;

   assign s3_adv       = !s3_vld || bus.out_ready;
   assign s2_adv       = !s2_vld || s3_adv;
   assign s1_adv       = !s1_vld || s2_adv;
   assign bus.in_ready = s1_adv;

   fpaddsub_lzc #(.W(SUM_W), .CW(LZ_W)) u_lzc (.d(bus.in_sum), .cnt(in_lz));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_sign <= 1'b0;
         s1_exp  <= '0;
         s1_sum  <= '0;
         s1_lz   <= '0;
      end else if (s1_adv) begin
         s1_vld <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sign <= bus.in_sign;
            s1_exp  <= bus.in_exp;
            s1_sum  <= bus.in_sum;
            s1_lz   <= in_lz;
         end
      end
   end

   // Classify and apply the coarse (multiple-of-4) part of the left shift.
   always_comb begin
      carry   = s1_sum[SUM_W-1];
      zero    = (s1_sum == '0);
      shl     = s1_lz - LZ_W'(1);
      exp_inc = {1'b0, s1_exp} + (EXP_W+1)'(1);
      s2_nxt      = '0;
      s2_nxt.sign = s1_sign;
      if (carry) begin
         s2_nxt.exp         = exp_inc;
         s2_nxt.man         = s1_sum >> 1;
         s2_nxt.sticky      = s1_sum[0];
         // >= also catches an all-ones input exponent, which must not wrap
         s2_nxt.flags.oflow = (exp_inc >= (EXP_W+1)'(EXP_ONES));
      end else if (zero) begin
         s2_nxt.flags.zero  = 1'b1;
      end else begin
         s2_nxt.exp         = {1'b0, s1_exp};
         s2_nxt.man         = s1_sum << {shl[LZ_W-1:2], 2'b00};
         s2_nxt.lz          = shl;
         s2_nxt.flags.uflow = ({1'b0, s1_exp} <= (EXP_W+1)'(shl));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_vld <= 1'b0;
         s2     <= '0;
      end else if (s2_adv) begin
         s2_vld <= s1_vld;
         if (s1_vld) s2 <= s2_nxt;
      end
   end

   // Fine shift and exponent adjust; lz carries the full left-shift amount.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_vld   <= 1'b0;
         o_man    <= '0;
         o_exp    <= '0;
         o_sign   <= 1'b0;
         o_sticky <= 1'b0;
         o_flags  <= '0;
      end else if (s3_adv) begin
         s3_vld <= s2_vld;
         if (s2_vld) begin
            o_sign   <= s2.sign;
            o_sticky <= s2.sticky;
            o_flags  <= s2.flags;
            if (s2.flags.zero || s2.flags.uflow) begin
               o_exp <= '0;
               o_man <= '0;
            end else if (s2.flags.oflow) begin
               o_exp <= '1;
               o_man <= '0;
            end else begin
               o_exp <= EXP_W'(s2.exp - (EXP_W+1)'(s2.lz));
               o_man <= (MAN_W+1)'(s2.man << s2.lz[1:0]);
            end
         end
      end
   end

   assign bus.out_valid  = s3_vld;
   assign bus.out_man    = o_man;
   assign bus.out_exp    = o_exp;
   assign bus.out_sign   = o_sign;
   assign bus.out_sticky = o_sticky;
   assign bus.out_zero   = o_flags.zero;
   assign bus.out_uflow  = o_flags.uflow;
   assign bus.out_oflow  = o_flags.oflow;

endmodule
